// File: rtl/opamp_sar_readout_if.sv
// Signal bundle between the SAR readout controller and its analog tile:
// enable/start/comparator inputs in, DAC trial code and conversion status out.
interface opamp_sar_readout_if #(
    parameter int WIDTH = 8
);
    logic             ena;
    logic             start;
    logic             comp_in;
    logic [WIDTH-1:0] dac_code;
    logic             sample;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] result;

    modport master (
        output ena, start, comp_in,
        input  dac_code, sample, busy, valid, result
    );

    modport slave (
        input  ena, start, comp_in,
        output dac_code, sample, busy, valid, result
    );
endinterface

// File: rtl/opamp_sar_readout.sv
// Successive-approximation readout controller: track/hold strobe, binary-search
// trial codes to the DAC, and a synchronised comparator decision per bit.
module opamp_sar_readout #(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    opamp_sar_readout_if.slave   bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW = $clog2(SAMPLE_CYCLES) + 1;
    localparam int TW = $clog2(SETTLE_CYCLES) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SAMPLE  = 2'd1,
        S_CONVERT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    smp_cnt_q, smp_cnt_d;
    logic [TW-1:0]    set_cnt_q, set_cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] dac_code_q, dac_code_d;
    logic             sample_q, sample_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             sync1_q, sync2_q;
    logic             comp_s;

    assign comp_s = sync2_q;

    // State register; outputs are registered alongside so none is combinational.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            smp_cnt_q  <= '0;
            set_cnt_q  <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            dac_code_q <= '0;
            sample_q   <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            smp_cnt_q  <= smp_cnt_d;
            set_cnt_q  <= set_cnt_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            dac_code_q <= dac_code_d;
            sample_q   <= sample_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            sync1_q    <= bus.comp_in;
            sync2_q    <= sync1_q;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        smp_cnt_d = smp_cnt_q;
        set_cnt_d = set_cnt_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        if (!bus.ena) begin
            state_d   = S_IDLE;
            acc_d     = '0;
            smp_cnt_d = '0;
            set_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d   = S_SAMPLE;
                        smp_cnt_d = '0;
                    end
                end
                S_SAMPLE: begin
                    if (smp_cnt_q == SW'(SAMPLE_CYCLES - 1)) begin
                        state_d   = S_CONVERT;
                        idx_d     = IW'(WIDTH - 1);
                        acc_d     = '0;
                        set_cnt_d = '0;
                    end else begin
                        smp_cnt_d = smp_cnt_q + 1'b1;
                    end
                end
                S_CONVERT: begin
                    if (set_cnt_q == TW'(SETTLE_CYCLES - 1)) begin
                        acc_d[idx_q] = comp_s;
                        if (idx_q == '0) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d     = idx_q - 1'b1;
                            set_cnt_d = '0;
                        end
                    end else begin
                        set_cnt_d = set_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs follow the state being entered, so they change on the same edge.
    always_comb begin
        dac_code_d = '0;
        sample_d   = 1'b0;
        busy_d     = 1'b0;
        valid_d    = 1'b0;
        result_d   = result_q;
        case (state_d)
            S_SAMPLE: begin
                sample_d = 1'b1;
                busy_d   = 1'b1;
            end
            S_CONVERT: begin
                busy_d     = 1'b1;
                dac_code_d = acc_d | (WIDTH'(1) << idx_d);
            end
            S_DONE: begin
                valid_d  = 1'b1;
                result_d = acc_d;
            end
            default: begin
                dac_code_d = '0;
            end
        endcase
    end

    assign bus.dac_code = dac_code_q;
    assign bus.sample   = sample_q;
    assign bus.busy     = busy_q;
    assign bus.valid    = valid_q;
    assign bus.result   = result_q;
endmodule

// File: tb/tb_opamp_sar_readout.sv
// Directed bench for opamp_sar_readout: comparator model (target >= dac_code),
// per-cycle output logging, and hand-computed timing/result expectations.
module tb_opamp_sar_readout;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    opamp_sar_readout_if #(.WIDTH(8)) bus ();

    opamp_sar_readout #(
        .WIDTH(8),
        .SAMPLE_CYCLES(4),
        .SETTLE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] code_log   [0:63];
    logic [7:0] result_log [0:63];
    bit         sample_log [0:63];
    bit         busy_log   [0:63];
    bit         valid_log  [0:63];

    int n_busy, first_busy, last_busy;
    int n_sample, first_sample, last_sample;
    int n_valid, first_valid;

    logic [7:0] exp_codes [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One conversion run. Cycle k is the interval following edge k-1, edge 0
    // being the one that samples start=1 in IDLE.
    task automatic run_conv(input logic [7:0] tgt, input bit delayed, input bit hold,
                            input bit repulse, input int abort_at, input int rst_at,
                            input int ncyc);
        logic [7:0] prev_code;
        bit         in_reset;
        in_reset      = 1'b0;
        prev_code     = 8'h00;
        bus.ena       = 1'b1;
        bus.start     = 1'b1;
        bus.comp_in   = (tgt >= bus.dac_code);
        @(posedge clk);
        #1;
        for (int k = 1; k <= ncyc && !in_reset; k++) begin
            code_log[k]   = bus.dac_code;
            result_log[k] = bus.result;
            sample_log[k] = bus.sample;
            busy_log[k]   = bus.busy;
            valid_log[k]  = bus.valid;
            if (k == rst_at) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("rst_dac_code", {24'd0, bus.dac_code}, 32'd0);
                check("rst_sample",   {31'd0, bus.sample},   32'd0);
                check("rst_busy",     {31'd0, bus.busy},     32'd0);
                check("rst_valid",    {31'd0, bus.valid},    32'd0);
                check("rst_result",   {24'd0, bus.result},   32'd0);
                in_reset = 1'b1;
            end else begin
                bus.start   = hold || (repulse && (k == 10 || k == 37));
                bus.ena     = !(abort_at > 0 && k >= abort_at);
                bus.comp_in = delayed ? (tgt >= prev_code) : (tgt >= bus.dac_code);
                prev_code   = bus.dac_code;
                @(posedge clk);
                #1;
            end
        end
        bus.start = 1'b0;
        if (!in_reset) begin
            bus.ena = 1'b0;
            @(posedge clk);
            #1;
            bus.ena = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic summarize(input int ncyc);
        n_busy = 0; first_busy = -1; last_busy = -1;
        n_sample = 0; first_sample = -1; last_sample = -1;
        n_valid = 0; first_valid = -1;
        for (int k = 1; k <= ncyc; k++) begin
            if (busy_log[k]) begin
                n_busy++;
                if (first_busy < 0) first_busy = k;
                last_busy = k;
            end
            if (sample_log[k]) begin
                n_sample++;
                if (first_sample < 0) first_sample = k;
                last_sample = k;
            end
            if (valid_log[k]) begin
                n_valid++;
                if (first_valid < 0) first_valid = k;
            end
        end
    endtask

    initial begin
        bus.ena     = 1'b0;
        bus.start   = 1'b0;
        bus.comp_in = 1'b0;
        #12;
        check("reset_dac_code", {24'd0, bus.dac_code}, 32'd0);
        check("reset_sample",   {31'd0, bus.sample},   32'd0);
        check("reset_busy",     {31'd0, bus.busy},     32'd0);
        check("reset_valid",    {31'd0, bus.valid},    32'd0);
        check("reset_result",   {24'd0, bus.result},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic conversion of 0xA5
        run_conv(8'hA5, 1'b0, 1'b0, 1'b0, 0, 0, 45);
        summarize(45);
        for (int i = 0; i < 8; i++)
            check($sformatf("basic_trial%0d", i), {24'd0, code_log[5 + 4 * i]}, {24'd0, exp_codes[i]});
        check("basic_result",      {24'd0, result_log[37]}, 32'h A5);
        check("basic_valid_cycle", first_valid, 37);
        check("basic_valid_count", n_valid, 1);
        check("basic_busy_first",  first_busy, 1);
        check("basic_busy_last",   last_busy, 36);
        check("basic_busy_count",  n_busy, 36);
        $display("conv basic   tgt=a5 result=%h valid_cycle=%0d", result_log[37], first_valid);

        // Rails
        run_conv(8'hFF, 1'b0, 1'b0, 1'b0, 0, 0, 45);
        summarize(45);
        check("rail1_result",       {24'd0, result_log[37]}, 32'hFF);
        check("rail1_sample_first", first_sample, 1);
        check("rail1_sample_last",  last_sample, 4);
        check("rail1_sample_count", n_sample, 4);
        $display("conv rail1   tgt=ff result=%h", result_log[37]);

        run_conv(8'h00, 1'b0, 1'b0, 1'b0, 0, 0, 45);
        summarize(45);
        check("rail0_result",       {24'd0, result_log[37]}, 32'h00);
        check("rail0_sample_first", first_sample, 1);
        check("rail0_sample_last",  last_sample, 4);
        check("rail0_sample_count", n_sample, 4);
        $display("conv rail0   tgt=00 result=%h", result_log[37]);

        // Start re-pulsed at cycles 10 and 37 must be ignored
        run_conv(8'hA5, 1'b0, 1'b0, 1'b1, 0, 0, 45);
        summarize(45);
        check("repulse_valid_count", n_valid, 1);
        check("repulse_valid_cycle", first_valid, 37);
        check("repulse_busy_count",  n_busy, 36);
        check("repulse_result",      {24'd0, result_log[45]}, 32'hA5);
        $display("conv repulse tgt=a5 result=%h valids=%0d", result_log[45], n_valid);

        // Start held high: next conversion starts sampling at cycle 39
        run_conv(8'hA5, 1'b0, 1'b1, 1'b0, 0, 0, 45);
        summarize(45);
        check("hold_valid_cycle", first_valid, 37);
        check("hold_sample_c38",  {31'd0, sample_log[38]}, 32'd0);
        check("hold_sample_c39",  {31'd0, sample_log[39]}, 32'd1);
        $display("conv hold    tgt=a5 result=%h second_sample=%0b", result_log[37], sample_log[39]);

        // Abort by dropping ena at cycle 20
        run_conv(8'h11, 1'b0, 1'b0, 1'b0, 20, 0, 45);
        summarize(45);
        check("abort_busy_c21",   {31'd0, busy_log[21]}, 32'd0);
        check("abort_dac_c21",    {24'd0, code_log[21]}, 32'd0);
        check("abort_valid_count", n_valid, 0);
        check("abort_result",     {24'd0, result_log[45]}, 32'hA5);
        $display("conv abort   tgt=11 result=%h valids=%0d", result_log[45], n_valid);

        // Asynchronous reset mid-conversion, then a fresh conversion
        run_conv(8'h77, 1'b0, 1'b0, 1'b0, 0, 15, 45);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_conv(8'h3C, 1'b0, 1'b0, 1'b0, 0, 0, 45);
        summarize(45);
        check("post_rst_result", {24'd0, result_log[37]}, 32'h3C);
        check("post_rst_valid",  first_valid, 37);
        $display("conv postrst tgt=3c result=%h", result_log[37]);

        // Comparator model lags each new trial code by one cycle
        run_conv(8'h5A, 1'b1, 1'b0, 1'b0, 0, 0, 45);
        summarize(45);
        check("sync_lag_result", {24'd0, result_log[37]}, 32'h5A);
        $display("conv synclag tgt=5a result=%h", result_log[37]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/opamp_sar_readout.md
# opamp_sar_readout

Successive-approximation readout controller that digitises the differential output of the on-chip fully differential opamp. It drives a track/hold strobe and a WIDTH-bit trial code into an external/analog DAC, and reads back a single-bit comparator decision. It sits in the digital half of the analog tile: `ui_in` carries the comparator and start inputs, and `uo_out`/`uio_out` carry the DAC code and status.

## Interface

- `WIDTH`, default 8: conversion resolution in bits; legal range 2..8.
- `SAMPLE_CYCLES`, default 4: number of cycles `sample` is held high per conversion; must be ≥1.
- `SETTLE_CYCLES`, default 4: cycles spent on each trial bit; must be ≥3, to cover 2 synchroniser cycles plus DAC settling.

Ports:

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `ena`  in  1  block enable; low aborts any conversion.
- `start`  in  1  level-sampled conversion request.
- `comp_in`  in  1  asynchronous comparator output; 1 = opamp output > DAC level.
- `dac_code`  out  WIDTH  trial code to the DAC.
- `sample`  out  1  track/hold control; 1 = track.
- `busy`  out  1  high from the first SAMPLE cycle through the last CONVERT cycle.
- `valid`  out  1  one-cycle pulse when `result` is updated.
- `result`  out  WIDTH  last completed conversion.

## Operation

- `comp_in` passes through a 2-flop synchroniser to produce `comp_s`. Only `comp_s` is used.
- States: IDLE, SAMPLE, CONVERT, DONE.
- **IDLE**
  - Outputs: `dac_code`=0, `sample`=0, `busy`=0.
  - `start`=1 and `ena`=1 at an edge → SAMPLE. The sample counter is loaded with 0.
- **SAMPLE**
  - Outputs: `sample`=1, `busy`=1, `dac_code`=0.
  - After SAMPLE_CYCLES cycles → CONVERT.
  - On entry to CONVERT: bit index = WIDTH-1; working register `acc` = 0; settle counter = 0.
- **CONVERT**
  - `dac_code` = `acc` with bit[index] forced to 1 (the trial code). `sample`=0, `busy`=1.
  - The settle counter runs 0..SETTLE_CYCLES-1.
  - On the edge ending count SETTLE_CYCLES-1:
    - `acc`[index] takes the value of `comp_s`: 1 keeps the bit, 0 clears it.
    - If index = 0 → DONE. Otherwise index decrements and the settle counter clears.
- **DONE** (one cycle)
  - `result` ← `acc`, `valid`=1, `busy`=0, `dac_code`=0.
  - Next state is IDLE.
  - `start` seen in DONE is ignored. A request must be held or re-asserted in IDLE.
- `start` is ignored in SAMPLE, CONVERT and DONE.
- `ena`=0 in any state → IDLE at the next edge.
  - No `valid` pulse is produced and `result` is unchanged.
  - `acc` is discarded.
- Reset (asynchronous, any state):
  - State → IDLE.
  - `dac_code`, `result`, `acc` and all counters → 0.
  - `sample`, `busy`, `valid` → 0.
  - Both synchroniser flops → 0.

## Timing

- Let cycle 0 be the edge that samples `start`=1 in IDLE.
  - SAMPLE occupies cycles 1..SAMPLE_CYCLES.
  - CONVERT occupies cycles SAMPLE_CYCLES+1 .. SAMPLE_CYCLES+WIDTH×SETTLE_CYCLES.
  - DONE, with `valid`=1, is at cycle SAMPLE_CYCLES+WIDTH×SETTLE_CYCLES+1. For the defaults this is cycle 37.
- Each trial code is stable for exactly SETTLE_CYCLES cycles.
  - The decision uses the comparator value present at `comp_in` 2 edges before the decision edge.
  - Stimulus must therefore reflect the new code within SETTLE_CYCLES-2 cycles.
- Minimum start-to-start period is SAMPLE_CYCLES+WIDTH×SETTLE_CYCLES+2 cycles, because IDLE is always visited for at least one cycle.
- `result` is stable from the DONE edge until the next DONE. It is never partially updated.
- All outputs are registered; none is combinational from inputs.

## Test plan

- **Basic conversion.** Comparator model: `comp_in` = (0xA5 > `dac_code`) ? 1 : 0; the comparison uses ≥ on bits kept so that 0xA5 resolves exactly. Pulse `start`.
  - Trial codes in order: 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
  - `valid` at cycle 37 with `result`=0xA5.
  - `busy` is high during cycles 1..36.
- **Rails.**
  - `comp_in` held 1 → `result`=0xFF.
  - `comp_in` held 0 → `result`=0x00.
  - In both cases `sample` is high exactly during cycles 1..4.
- **Ignored start.** Re-pulse `start` at cycles 10 and 37.
  - Exactly one `valid`, at cycle 37. No second conversion follows.
  - Holding `start` high instead → the next conversion begins, with `sample` high from cycle 39.
- **Abort.** Drop `ena` at cycle 20.
  - Cycle 21: `busy`=0 and `dac_code`=0.
  - No `valid` pulse; `result` keeps its previous value, e.g. 0xA5.
- **Reset mid-conversion.** Assert `rst_n`=0 asynchronously at cycle 15, between edges.
  - All outputs are 0 immediately.
  - After release, a fresh conversion of 0x3C yields `result`=0x3C.
- **Synchroniser latency.** Change the model value only 1 cycle after each new trial code.
  - `result` still matches the target, e.g. 0x5A.
